// File: rtl/pri_pkg.sv
// Shared types and sizing constants for the priority decoder block.
package pri_pkg;

    localparam int CODE_W = 3;
    localparam int LINES  = 8;
    localparam int CNT_W  = 8;
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/pri_deco_3to8.sv
// 3-to-8 one-hot decoder: code 000 drives line 7, code 111 drives line 0.
module pri_deco_3to8
    import pri_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    input  logic              en_i,
    output logic [LINES-1:0]  onehot_o
);

    // Decode the code to a single active line, or all-zero when disabled.
    always_comb begin
        onehot_o = {LINES{1'b0}};
        if (en_i) begin
            onehot_o[3'd7 - code_i] = 1'b1;
        end else begin
            onehot_o = {LINES{1'b0}};
        end
    end

endmodule

// File: rtl/pri_deco.sv
// Priority-code grant generator: accepts a code, holds the matching one-hot
// grant for HOLD_CYCLES cycles, then pulses done and bumps the completion count.
module pri_deco
    import pri_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic              v,
    output logic              ready,
    output logic [LINES-1:0]  grant,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_e              state_q;
    logic [CODE_W-1:0]   code_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [CNT_W-1:0]    count_q;
    logic [LINES-1:0]    grant_q;

    logic                accept_s;
    logic                keep_s;
    logic [CODE_W-1:0]   dec_code_s;
    logic                dec_en_s;
    logic [LINES-1:0]    dec_s;

    // A code is taken only when idle, enabled and valid.
    assign accept_s = en && v && (state_q == IDLE);

    // Grant stays up while in GRANT with more hold cycles left and en high.
    assign keep_s = (state_q == GRANT) && en && (hold_q != {HOLD_W{1'b0}});

    // On acceptance decode the incoming code; afterwards only the captured one.
    assign dec_code_s = accept_s ? code : code_q;
    assign dec_en_s   = accept_s || keep_s;

    pri_deco_3to8 u_dec (
        .code_i   (dec_code_s),
        .en_i     (dec_en_s),
        .onehot_o (dec_s)
    );

    // Control FSM with capture register, hold counter, grant and completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= {CODE_W{1'b0}};
            hold_q  <= {HOLD_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            grant_q <= {LINES{1'b0}};
        end else begin
            grant_q <= dec_s;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q <= GRANT;
                        code_q  <= code;
                        hold_q  <= HOLD_LOAD;
                    end
                end
                GRANT: begin
                    if (!en) begin
                        state_q <= IDLE;
                        hold_q  <= {HOLD_W{1'b0}};
                    end else if (hold_q == {HOLD_W{1'b0}}) begin
                        state_q <= DONE;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                DONE: begin
                    count_q <= count_q + CNT_W'(1);
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    hold_q  <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == GRANT) || (state_q == DONE);
    assign done  = (state_q == DONE);
    assign grant = grant_q;
    assign count = count_q;

endmodule

// File: tb/tb_pri_deco.sv
// Self-checking bench for pri_deco: two instances (hold 4 and hold 1) share
// stimulus and are compared every cycle against a remaining-cycles model.
module tb_pri_deco;

    logic       clk;
    logic       rst;
    logic       en;
    logic       v;
    logic [2:0] code;

    logic       rdy0, busy0, done0;
    logic [7:0] gnt0, cnt0;
    logic       rdy1, busy1, done1;
    logic [7:0] gnt1, cnt1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state per instance.
    int gleft [2];
    int line  [2];
    int cnt   [2];
    bit dflag [2];
    int hold_of [2];

    pri_deco #(.HOLD_CYCLES(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .code(code), .v(v),
        .ready(rdy0), .grant(gnt0), .busy(busy0), .done(done0), .count(cnt0)
    );

    pri_deco #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .code(code), .v(v),
        .ready(rdy1), .grant(gnt1), .busy(busy1), .done(done1), .count(cnt1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input logic r, input logic e,
                              input logic vv, input logic [2:0] c);
        if (r) begin
            gleft[i] = 0; dflag[i] = 1'b0; cnt[i] = 0; line[i] = 0;
        end else if (dflag[i]) begin
            dflag[i] = 1'b0;
            cnt[i]   = (cnt[i] + 1) % 256;
        end else if (gleft[i] > 0) begin
            if (!e) gleft[i] = 0;
            else if (gleft[i] == 1) begin
                gleft[i] = 0;
                dflag[i] = 1'b1;
            end else gleft[i] = gleft[i] - 1;
        end else if (e && vv) begin
            gleft[i] = hold_of[i];
            line[i]  = 7 - int'(c);
        end
    endtask

    function automatic logic [7:0] exp_grant(input int i);
        logic [7:0] g;
        g = 8'h00;
        if (gleft[i] > 0) g[line[i]] = 1'b1;
        return g;
    endfunction

    task automatic compare_all();
        logic eb0, eb1;
        eb0 = (gleft[0] > 0) || dflag[0];
        eb1 = (gleft[1] > 0) || dflag[1];
        chk("h4.grant", gnt0, exp_grant(0));
        chk("h4.busy",  {7'd0, busy0}, {7'd0, eb0});
        chk("h4.ready", {7'd0, rdy0},  {7'd0, ~eb0});
        chk("h4.done",  {7'd0, done0}, {7'd0, dflag[0]});
        chk("h4.count", cnt0, 8'(cnt[0]));
        chk("h1.grant", gnt1, exp_grant(1));
        chk("h1.busy",  {7'd0, busy1}, {7'd0, eb1});
        chk("h1.ready", {7'd0, rdy1},  {7'd0, ~eb1});
        chk("h1.done",  {7'd0, done1}, {7'd0, dflag[1]});
        chk("h1.count", cnt1, 8'(cnt[1]));
    endtask

    task automatic step(input logic r, input logic e, input logic vv, input logic [2:0] c);
        rst = r; en = e; v = vv; code = c;
        @(posedge clk);
        model_edge(0, r, e, vv, c);
        model_edge(1, r, e, vv, c);
        #1;
        compare_all();
    endtask

    initial begin
        hold_of[0] = 4; hold_of[1] = 1;
        for (int i = 0; i < 2; i++) begin
            gleft[i] = 0; line[i] = 0; cnt[i] = 0; dflag[i] = 1'b0;
        end
        rst = 1'b1; en = 1'b0; v = 1'b0; code = 3'd0;
        #2;

        // Reset state, then first cycle out of reset.
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd5);
        step(1'b0, 1'b0, 1'b0, 3'd0);

        // Single transfer with code 000, then drain.
        step(1'b0, 1'b1, 1'b1, 3'd0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 3'd0);

        // v with en low is ignored in idle.
        repeat (3) step(1'b0, 1'b0, 1'b1, 3'd2);

        // Sweep every code.
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 1'b1, 1'b1, 3'(c));
            repeat (5) step(1'b0, 1'b1, 1'b0, 3'd0);
        end

        // Abort with en low in the second grant cycle.
        step(1'b0, 1'b1, 1'b1, 3'd3);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        repeat (4) step(1'b0, 1'b1, 1'b0, 3'd0);

        // v held high with changing code: back-to-back acceptances.
        for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 1'b1, 3'(k));
        repeat (6) step(1'b0, 1'b1, 1'b0, 3'd0);

        // en low while in DONE must not suppress the pulse or count.
        step(1'b0, 1'b1, 1'b1, 3'd6);
        repeat (3) step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b0, 1'b0, 3'd0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 3'd0);

        // Reset mid-grant after five completions.
        step(1'b1, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b1, 3'd1);
            repeat (5) step(1'b0, 1'b1, 1'b0, 3'd0);
        end
        step(1'b0, 1'b1, 1'b1, 3'd4);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 3'd7);
        step(1'b0, 1'b1, 1'b0, 3'd0);

        // 256 completions: count wraps.
        for (int k = 0; k < 256; k++) begin
            step(1'b0, 1'b1, 1'b1, 3'(k));
            repeat (5) step(1'b0, 1'b1, 1'b0, 3'd0);
        end

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pri_deco.md
PRI_DECO -- requirements
Module: pri_deco

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a grant line stays asserted; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  block enable; low aborts any grant in progress and blocks acceptance.
REQ-005 code  input  3  priority code from the encoder side; 000 = line 7 (highest), 111 = line 0 (lowest).
REQ-006 v  input  1  code valid.
REQ-007 ready  output  1  block can accept a code this cycle.
REQ-008 grant  output  8  registered one-hot grant; bit index = 7 - code.
REQ-009 busy  output  1  high while a grant is held or completing.
REQ-010 done  output  1  one-cycle pulse marking normal completion of a grant.
REQ-011 count  output  8  number of grants completed normally, wrapping.

Function
REQ-012 FSM states SHALL be IDLE, GRANT and DONE.
REQ-013 IDLE: ready=1, grant=0, busy=0, done=0.
REQ-014 Acceptance SHALL occur on the edge where en=1, v=1 and ready=1; code is captured into a register; state moves to GRANT; hold counter loads HOLD_CYCLES-1.
REQ-015 In IDLE, v=1 with en=0 SHALL be ignored, and v=0 SHALL leave the state in IDLE.
REQ-016 GRANT: grant = one-hot(7 - captured code), busy=1, ready=0; counter decrements each cycle.
REQ-017 Latency: grant SHALL be visible in the cycle after acceptance and SHALL be held for exactly HOLD_CYCLES cycles.
REQ-018 GRANT to DONE SHALL occur when the counter equals 0 and en=1.
REQ-019 DONE SHALL last one cycle with grant=0, done=1, busy=1, ready=0; count increments by 1 (255 wraps to 0); next state is IDLE.
REQ-020 en=0 sampled in GRANT SHALL cause IDLE on the next edge with grant=0; no done pulse; count unchanged.
REQ-021 en=0 sampled in DONE SHALL NOT suppress that cycle's done pulse or count increment.
REQ-022 code and v SHALL be ignored outside IDLE; the captured code SHALL NOT change during GRANT.
REQ-023 Back-to-back transfers: minimum spacing between acceptances is HOLD_CYCLES+2 cycles.
REQ-024 grant SHALL be all-zero or exactly one-hot in every cycle, never X.
REQ-025 All outputs SHALL be driven from registers or decoded from the state register only; no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge: grant=0, busy=0, done=0, count=0, hold counter=0, captured code=000.
REQ-027 rst SHALL take priority over en, v and all state transitions, including mid-GRANT and in DONE; no done pulse is generated.
REQ-028 ready SHALL read 1 in the first cycle after rst deasserts.

Structure
REQ-029 Shared package pri_pkg SHALL hold: state enum, CODE_W=3, LINES=8, CNT_W=8, HOLD_W=4.
REQ-030 Combinational sub-module pri_deco_3to8 SHALL map a 3-bit code plus enable to the 8-bit one-hot output (bit 7-code); pri_deco instantiates it once.
REQ-031 Estimated size is 120-250 RTL lines.

Verification
REQ-032 HOLD_CYCLES=4, code=000, v=1, en=1 for one cycle -> grant=8'b1000_0000 for 4 cycles, then done=1 for 1 cycle, count=1, ready=1 on the following cycle.
REQ-033 Sweep code 000..111, one at a time -> grant = 80,40,20,10,08,04,02,01 (hex); count=8 at the end.
REQ-034 code=011 accepted, en=0 in the 2nd GRANT cycle -> grant=0 and IDLE on the next edge; done never pulses; count unchanged.
REQ-035 v held at 1 with changing code during GRANT -> grant unchanged; the next acceptance occurs exactly HOLD_CYCLES+2 cycles after the first.
REQ-036 rst=1 mid-GRANT with count=5 -> next cycle grant=0, count=0, ready=1; no done pulse.
REQ-037 256 normal completions -> count wraps to 0; HOLD_CYCLES=1 -> grant is exactly 1 cycle wide, followed by done.
